// File: rtl/seq_divider.sv
// Sequential restoring shift-subtract divider: 2N-bit dividend by N-bit divisor,
// one quotient bit per clock, start/done handshake matching the shift-and-add multiplier.
module seq_divider #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;

    logic [W-1:0]    q_r;
    logic [N-1:0]    d_r;
    logic [N:0]      r_r;
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    quotient_r;
    logic [N-1:0]    remainder_r;
    logic            busy_r;
    logic            done_r;
    logic            dz_r;

    logic [W-1:0]    q_nx_s;
    logic [N-1:0]    d_nx_s;
    logic [N:0]      r_nx_s;
    logic [CW-1:0]   cnt_nx_s;
    logic [W-1:0]    quotient_nx_s;
    logic [N-1:0]    remainder_nx_s;
    logic            dz_nx_s;

    logic [N:0]      sh_r_s;
    logic [W-1:0]    sh_q_s;
    logic [N:0]      diff_s;
    logic [N:0]      iter_r_s;
    logic [W-1:0]    iter_q_s;

    // One restoring step: shift {R,Q}, trial-subtract D, keep the difference if non-negative.
    always_comb begin
        {sh_r_s, sh_q_s} = {r_r, q_r} << 1'b1;
        diff_s = sh_r_s - {1'b0, d_r};
        if (diff_s[N] == 1'b0) begin
            iter_r_s = diff_s;
            iter_q_s = {sh_q_s[W-1:1], 1'b1};
        end else begin
            iter_r_s = sh_r_s;
            iter_q_s = sh_q_s;
        end
    end

    // Next-state and next-datapath decode; results only change on entry to DONE.
    always_comb begin
        state_nx_s     = state_r;
        q_nx_s         = q_r;
        d_nx_s         = d_r;
        r_nx_s         = r_r;
        cnt_nx_s       = cnt_r;
        quotient_nx_s  = quotient_r;
        remainder_nx_s = remainder_r;
        dz_nx_s        = dz_r;
        case (state_r)
            IDLE: begin
                if (start == 1'b1) begin
                    if (divisor != {N{1'b0}}) begin
                        q_nx_s     = dividend;
                        d_nx_s     = divisor;
                        r_nx_s     = {(N+1){1'b0}};
                        cnt_nx_s   = {CW{1'b0}};
                        state_nx_s = RUN;
                    end else begin
                        quotient_nx_s  = {W{1'b1}};
                        remainder_nx_s = dividend[N-1:0];
                        dz_nx_s        = 1'b1;
                        state_nx_s     = DONE;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                q_nx_s   = iter_q_s;
                r_nx_s   = iter_r_s;
                cnt_nx_s = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    quotient_nx_s  = iter_q_s;
                    remainder_nx_s = iter_r_s[N-1:0];
                    dz_nx_s        = 1'b0;
                    state_nx_s     = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath and registered outputs; busy/done are decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r         <= {W{1'b0}};
            d_r         <= {N{1'b0}};
            r_r         <= {(N+1){1'b0}};
            cnt_r       <= {CW{1'b0}};
            quotient_r  <= {W{1'b0}};
            remainder_r <= {N{1'b0}};
            dz_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            q_r         <= q_nx_s;
            d_r         <= d_nx_s;
            r_r         <= r_nx_s;
            cnt_r       <= cnt_nx_s;
            quotient_r  <= quotient_nx_s;
            remainder_r <= remainder_nx_s;
            dz_r        <= dz_nx_s;
            busy_r      <= (state_nx_s != IDLE);
            done_r      <= (state_nx_s == DONE);
        end
    end

    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign dz        = dz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (N=4): directed corner cases, mid-run start/reset,
// held start, and a shuffled sweep of every non-zero divisor pair against plain / and %.
module tb_seq_divider;

    localparam int N = 4;
    localparam int W = 2 * N;

    typedef struct {
        logic [W-1:0] dd;
        logic [N-1:0] dv;
        logic [W-1:0] q;
        logic [N-1:0] r;
        logic         dz;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  dividend;
    logic [N-1:0]  divisor;
    logic [W-1:0]  quotient;
    logic [N-1:0]  remainder;
    logic          busy;
    logic          done;
    logic          dz;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];
    logic [W-1:0]  prev_q;
    logic [N-1:0]  prev_r;

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    function automatic exp_t ref_model(input logic [W-1:0] dd, input logic [N-1:0] dv);
        exp_t e;
        e.dd = dd;
        e.dv = dv;
        if (dv == 0) begin
            e.q  = {W{1'b1}};
            e.r  = dd[N-1:0];
            e.dz = 1'b1;
        end else begin
            e.q  = W'(int'(dd) / int'(dv));
            e.r  = N'(int'(dd) % int'(dv));
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called #1 after a posedge with the DUT idle; returns #1 after the edge back to IDLE.
    task automatic run_op(input logic [W-1:0] dd, input logic [N-1:0] dv);
        exp_t e;
        int   lat;
        int   busy_cnt;
        bit   got;
        e = ref_model(dd, dv);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = N'($urandom);
        lat = 0;
        busy_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (i == 0 && dv != 0) begin
                chk("hold_quotient", quotient, prev_q);
                chk("hold_remainder", remainder, prev_r);
            end
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        chk("done_seen", got, 1'b1);
        chk("latency", lat, (dv == 0) ? 0 : W);
        chk("busy_cycles", busy_cnt, lat + 1);
        @(posedge clk);
        #1;
        chk("idle_busy", busy, 1'b0);
        chk("done_single", done, 1'b0);
        prev_q = e.q;
        prev_r = e.r;
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, ok, 1'b1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] pd[$];
        logic [N-1:0] pv[$];
        exp_t         e;

        fork
            begin
                exp_t m;
                forever begin
                    @(negedge clk);
                    if (!reset && done) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
                        end else begin
                            m = sb.pop_front();
                            checks++;
                            if (quotient !== m.q || remainder !== m.r || dz !== m.dz) begin
                                errors++;
                                $display("FAIL result %0d/%0d: got q=%0d r=%0d dz=%0d expected q=%0d r=%0d dz=%0d",
                                         m.dd, m.dv, quotient, remainder, dz, m.q, m.r, m.dz);
                            end
                            if (!m.dz) begin
                                checks++;
                                if (int'(quotient) * int'(m.dv) + int'(remainder) != int'(m.dd) ||
                                    int'(remainder) >= int'(m.dv)) begin
                                    errors++;
                                    $display("FAIL invariant %0d/%0d: got q=%0d r=%0d expected q*d+r=dividend and r<d",
                                             m.dd, m.dv, quotient, remainder);
                                end
                            end
                        end
                    end
                end
            end
        join_none

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        prev_q   = '0;
        prev_r   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dz", dz, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op(8'd200, 4'd7);
        run_op(8'd255, 4'd1);
        run_op(8'd0,   4'd5);
        run_op(8'd13,  4'd15);
        run_op(8'd255, 4'd15);
        run_op(8'd100, 4'd0);
        chk("dz_quotient", prev_q, 255);
        run_op(8'd100, 4'd3);

        // Start during RUN must be ignored.
        e = ref_model(8'd200, 4'd7);
        sb.push_back(e);
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        dividend = 8'd99;
        divisor  = 4'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain("ignored_start_drain");
        repeat (12) @(posedge clk);
        #1;
        chk("ignored_start_q", quotient, 28);
        chk("ignored_start_busy", busy, 0);
        prev_q = 8'd28;
        prev_r = 4'd4;

        // Reset in the middle of RUN discards the operation.
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        chk("midrst_done", done, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        prev_q = '0;
        prev_r = '0;
        repeat (12) @(posedge clk);
        #1;
        run_op(8'd50, 4'd6);

        // Held start relaunches from each IDLE cycle: three launches in 21 edges.
        for (int i = 0; i < 3; i++) sb.push_back(ref_model(8'd77, 4'd5));
        dividend = 8'd77;
        divisor  = 4'd5;
        start    = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        start = 1'b0;
        drain("held_start_drain");
        prev_q = 8'd15;
        prev_r = 4'd2;

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), N'($urandom_range(0, 15)));
        end

        for (int d = 1; d < 16; d++) begin
            for (int n = 0; n < 256; n++) begin
                pd.push_back(W'(n));
                pv.push_back(N'(d));
            end
        end
        for (int i = pd.size() - 1; i > 0; i--) begin
            int j;
            logic [W-1:0] td;
            logic [N-1:0] tv;
            j = int'($urandom_range(0, i));
            td = pd[i]; pd[i] = pd[j]; pd[j] = td;
            tv = pv[i]; pv[i] = pv[j]; pv[j] = tv;
        end
        for (int i = 0; i < pd.size(); i++) begin
            run_op(pd[i], pv[i]);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
